sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//  Multi-cycle bridge between the MEM stage and the board's external 16-bit SRAM (256K x 16).
//  Converts one 32-bit word read/write per request into two 16-bit SRAM accesses.
//  Holds ready low while busy so the pipeline freezes.
//  Sits directly downstream of MEM stage (replaces the on-chip data memory).
//  readdata feeds MEM_Stage_reg.
// PARAMETERS
//  WAIT_CYCLES   2      cycles spent on each 16-bit half access (>=1)
//  ADDR_OFFSET   1024   byte-address base subtracted from the ALU address before indexing
//  SRAM_AW       18     SRAM address width (half-word index)
// PORTS
//  clk        in     1        single clock, all state on rising edge
//  rst        in     1        synchronous, active-low reset (sampled on clk rising edge)
//  rd_en      in     1        MEM_R_En from EXE/MEM register
//  wr_en      in     1        MEM_W_En from EXE/MEM register
//  address    in     32       byte address (ALU result)
//  writedata  in     32       store data
//  readdata   out    32       load data, valid while ready=1 in DONE
//  ready      out    1        0 = freeze pipeline; 1 = request finished or idle
//  SRAM_DQ    inout  16       SRAM data bus, driven only in write phases, else high-Z
//  SRAM_ADDR  out    SRAM_AW  SRAM half-word address
//  SRAM_WE_N  out    1        write enable, active low
//  SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1 each   constant 0
// BEHAVIOUR
//  - Reset (rst=0 at a posedge) forces:
//    - state=IDLE, wait counter=0, readdata=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ high-Z.
//    - Reset wins over everything, including mid-operation; a partially written word is undefined.
//  - Word index: waddr = (address - ADDR_OFFSET) >> 2, truncated to SRAM_AW-1 bits (modulo wrap, no error).
//  - FSM states: IDLE -> LOW -> HIGH -> DONE -> IDLE.
//  - IDLE:
//    - ready = ~(rd_en | wr_en), combinational, so ready drops in the same cycle the request appears.
//    - On a request: latch op, waddr and writedata; next state LOW.
//    - rd_en and wr_en both 1: treated as a write.
//  - LOW (WAIT_CYCLES cycles):
//    - SRAM_ADDR = {waddr, 1'b0}; ready = 0.
//    - Write: SRAM_DQ = wdata[15:0], SRAM_WE_N = 0 for every cycle of the phase.
//    - Read: SRAM_WE_N = 1; readdata[15:0] <= SRAM_DQ at the edge that ends the phase.
//  - HIGH (WAIT_CYCLES cycles): same as LOW but with SRAM_ADDR = {waddr, 1'b1} and data bits [31:16].
//  - Phase boundaries: SRAM_WE_N is registered and returns to 1 at the edge that leaves HIGH. At the LOW->HIGH boundary on a write, SRAM_WE_N stays 0 while address and data switch together.
//  - DONE:
//    - Exactly 1 cycle, ready = 1; readdata holds the full word (reads) or the previous value (writes).
//    - rd_en/wr_en are ignored in DONE because they still belong to the finishing instruction.
//    - Next state is always IDLE.
//  - Latency:
//    - Request first visible in cycle 0: ready=0 in cycles 0..2*WAIT_CYCLES.
//    - ready=1 in cycle 2*WAIT_CYCLES+1; the pipeline advances at the edge ending that cycle.
//  - Back-to-back memory instructions: the second request is seen in IDLE the cycle after DONE. Each request costs 2*WAIT_CYCLES+2 cycles.
//  - readdata holds its value between requests; it is overwritten only by reads and by reset.
//  - Wait counter counts 0..WAIT_CYCLES-1 and clears on each phase change.
// TESTING
//  1. Reset held 3 cycles, rd_en=wr_en=0 -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, readdata=0.
//  2. WAIT_CYCLES=2, write 0xDEADBEEF to 1024:
//     - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
//     - ready low exactly cycles 0-4, high in cycle 5.
//     - SRAM_WE_N low cycles 1-4.
//  3. Read 1024 after test 2 -> readdata=0xDEADBEEF in DONE cycle; SRAM_WE_N stays 1 throughout; DQ never driven.
//  4. Write 0x12345678 to 1032, then immediately read 1032 -> second request starts the cycle after DONE; readdata=0x12345678; total 12 cycles.
//  5. rd_en=wr_en=1 at 1028 with data 0xA5A5_0F0F -> treated as write; SRAM[2]=0x0F0F, SRAM[3]=0xA5A5.
//  6. rst=0 during HIGH of a write -> next cycle state IDLE, SRAM_WE_N=1, DQ=Z, readdata=0; with the request still asserted after rst=1, the request restarts from LOW.

Source files
------------

// File: rtl/sram_controller_if.sv
// MEM-stage side of the external SRAM bridge: one 32-bit word request per transaction.
// ready low means "freeze"; rd_en/wr_en must stay asserted until ready returns high.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, writedata,
    input  readdata, ready
  );

  modport slave (
    input  rd_en, wr_en, address, writedata,
    output readdata, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges one 32-bit MEM-stage access onto two 16-bit accesses of the external SRAM.
// Sequence per request: IDLE -> LOW half -> HIGH half -> DONE (one ready cycle) -> IDLE.
module sram_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_OFFSET = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [1:0]         state_dbg
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic [CW-1:0]      wait_cnt;
  logic               is_write;
  logic [SRAM_AW-2:0] waddr;
  logic [15:0]        wdata_hi;
  logic [15:0]        dq_out;
  logic [31:0]        readdata_q;

  logic [31:0]        offs_addr;
  logic [SRAM_AW-2:0] waddr_next;
  logic               phase_end;
  logic               unused_addr_bits;

  // Word index wraps silently modulo the SRAM size, including addresses below the offset.
  assign offs_addr        = mem.address - 32'(ADDR_OFFSET);
  assign waddr_next       = offs_addr[SRAM_AW:2];
  assign unused_addr_bits = ^{offs_addr[31:SRAM_AW+1], offs_addr[1:0]};
  assign phase_end        = (wait_cnt == CW'(WAIT_CYCLES - 1));

  // The data bus is ours exactly while the (registered) write strobe is low.
  assign SRAM_DQ   = SRAM_WE_N ? 16'hzzzz : dq_out;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign mem.readdata = readdata_q;
  assign state_dbg    = state;

  always_comb begin
    mem.ready = 1'b0;
    case (state)
      IDLE:    mem.ready = ~(mem.rd_en | mem.wr_en);
      DONE:    mem.ready = 1'b1;
      default: mem.ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      is_write   <= 1'b0;
      waddr      <= '0;
      wdata_hi   <= '0;
      dq_out     <= '0;
      readdata_q <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (mem.rd_en | mem.wr_en) begin
            // A simultaneous read+write request is handled as a write.
            state     <= LOW;
            wait_cnt  <= '0;
            is_write  <= mem.wr_en;
            waddr     <= waddr_next;
            wdata_hi  <= mem.writedata[31:16];
            dq_out    <= mem.writedata[15:0];
            SRAM_ADDR <= {waddr_next, 1'b0};
            SRAM_WE_N <= ~mem.wr_en;
          end
        end
        LOW: begin
          if (phase_end) begin
            // Address and data switch together; the write strobe stays low across the boundary.
            state     <= HIGH;
            wait_cnt  <= '0;
            SRAM_ADDR <= {waddr, 1'b1};
            dq_out    <= wdata_hi;
            if (!is_write) readdata_q[15:0] <= SRAM_DQ;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            state     <= DONE;
            wait_cnt  <= '0;
            SRAM_WE_N <= 1'b1;
            if (!is_write) readdata_q[31:16] <= SRAM_DQ;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          // DONE: requests still belong to the finishing instruction, so they are ignored.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
